// File: rtl/divider_share_arbiter.sv
// Round-robin front end that time-shares one divider core among NUM_REQ requesters.
// One operation in flight; divide-by-zero is answered locally without touching the core.
module divider_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int RST_CYCLES  = 8,
    parameter int DIV_LATENCY = 40
) (
    input  logic                    divider_clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_num,
    input  logic [NUM_REQ*32-1:0]   req_den,
    output logic                    div_i_call,
    output logic                    div_reset_n,
    output logic [31:0]             div_num,
    output logic [31:0]             div_den,
    input  logic [31:0]             div_quo,
    input  logic [31:0]             div_rem,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             resp_quo,
    output logic [31:0]             resp_rem,
    output logic                    resp_dz,
    output logic                    busy
);

    localparam int MAX_CNT = (RST_CYCLES > DIV_LATENCY) ? RST_CYCLES : DIV_LATENCY;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  ptr, gnt_idx, id_q;
    logic             gnt_found;
    logic [31:0]      gnt_num, gnt_den;
    logic [31:0]      num_q, den_q, quo_q, rem_q;
    logic             dz_q;
    logic             load_last, run_last;
    int               idx;

    // First asserted requester at or after the pointer, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_num   = '0;
        gnt_den   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
                gnt_num   = req_num[32*idx +: 32];
                gnt_den   = req_den[32*idx +: 32];
            end
        end
    end

    assign load_last = (cnt == CNT_W'(RST_CYCLES - 1));
    assign run_last  = (cnt == CNT_W'(DIV_LATENCY - 1));

    always_ff @(posedge divider_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        div_i_call  = 1'b0;
        div_reset_n = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    for (int i = 0; i < NUM_REQ; i++)
                        req_ready[i] = (gnt_idx == ID_W'(i));
                    state_nxt = (gnt_den == 32'd0) ? RESP : LOAD;
                end
            end
            LOAD: begin
                div_i_call = 1'b1;
                if (load_last) state_nxt = RUN;
            end
            RUN: begin
                div_i_call  = 1'b1;
                div_reset_n = 1'b1;
                if (run_last) state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge divider_clk) begin
        if (reset) begin
            cnt   <= '0;
            ptr   <= '0;
            id_q  <= '0;
            num_q <= '0;
            den_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (gnt_found) begin
                        id_q  <= gnt_idx;
                        num_q <= gnt_num;
                        den_q <= gnt_den;
                        ptr   <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                        if (gnt_den == 32'd0) begin
                            quo_q <= 32'hFFFF_FFFF;
                            rem_q <= gnt_num;
                            dz_q  <= 1'b1;
                        end
                    end
                end
                LOAD: cnt <= load_last ? '0 : cnt + CNT_W'(1);
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (run_last) begin
                        quo_q <= div_quo;
                        rem_q <= div_rem;
                        dz_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_num    = num_q;
    assign div_den    = den_q;
    assign resp_valid = (state == RESP);
    assign resp_id    = id_q;
    assign resp_quo   = quo_q;
    assign resp_rem   = rem_q;
    assign resp_dz    = dz_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_divider_share_arbiter.sv
// Directed bench for divider_share_arbiter with a fixed-latency divider core model.
module tb_divider_share_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ID_W        = 2;
    localparam int RST_CYCLES  = 8;
    localparam int DIV_LATENCY = 40;
    localparam int LAT         = RST_CYCLES + DIV_LATENCY + 1;

    logic                  divider_clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_num = '0;
    logic [NUM_REQ*32-1:0] req_den = '0;
    logic                  div_i_call, div_reset_n;
    logic [31:0]           div_num, div_den, div_quo, div_rem;
    logic                  resp_valid;
    logic                  resp_ready = 1'b0;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_quo, resp_rem;
    logic                  resp_dz, busy;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, mcnt = 0, call_cnt = 0;

    divider_share_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .RST_CYCLES(RST_CYCLES), .DIV_LATENCY(DIV_LATENCY)
    ) dut (
        .divider_clk(divider_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_num(req_num), .req_den(req_den),
        .div_i_call(div_i_call), .div_reset_n(div_reset_n), .div_num(div_num), .div_den(div_den),
        .div_quo(div_quo), .div_rem(div_rem),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_quo(resp_quo), .resp_rem(resp_rem), .resp_dz(resp_dz), .busy(busy)
    );

    always #5 divider_clk = ~divider_clk;

    // Core model: result only becomes valid on the DIV_LATENCY-th cycle out of reset.
    always @(posedge divider_clk) begin
        cyc <= cyc + 1;
        if (!div_reset_n)             mcnt <= 0;
        else if (mcnt < DIV_LATENCY)  mcnt <= mcnt + 1;
        if (div_i_call) call_cnt <= call_cnt + 1;
    end

    always_comb begin
        div_quo = 32'hDEAD_BEEF;
        div_rem = 32'hDEAD_BEEF;
        if (div_reset_n && mcnt >= DIV_LATENCY - 1 && div_den != 0) begin
            div_quo = div_num / div_den;
            div_rem = div_num % div_den;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] n, input logic [31:0] d);
        req_valid[i]          = v;
        req_num[32*i +: 32]   = n;
        req_den[32*i +: 32]   = d;
    endtask

    task automatic wait_grant(output int g, output int gc);
        g  = -1;
        gc = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_ready != '0) begin
                for (int j = 0; j < NUM_REQ; j++) if (req_ready[j]) g = j;
                gc = cyc;
                check("onehot", 128'($countones(req_ready)), 128'd1);
                return;
            end
            @(negedge divider_clk);
        end
        check("grant_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_resp(output int rc);
        rc = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (resp_valid) begin
                rc = cyc;
                return;
            end
            @(negedge divider_clk);
        end
        check("resp_timeout", 128'd0, 128'd1);
    endtask

    // One full transaction: grant, 1-cycle pulse, latency and payload.
    task automatic serve(input string tag, input int exp_g, input logic [31:0] q,
                         input logic [31:0] r, input logic dz, input int lat,
                         input logic drop, output int gc);
        int g, rc;
        wait_grant(g, gc);
        check({tag, "_gnt"}, 128'(g), 128'(exp_g));
        @(negedge divider_clk);
        if (drop && g >= 0) req_valid[g] = 1'b0;
        #1 check({tag, "_pulse"}, 128'(req_ready), 128'd0);
        wait_resp(rc);
        check({tag, "_lat"}, 128'(rc - gc), 128'(lat));
        check({tag, "_id"},  128'(resp_id), 128'(exp_g));
        check({tag, "_quo"}, 128'(resp_quo), 128'(q));
        check({tag, "_rem"}, 128'(resp_rem), 128'(r));
        check({tag, "_dz"},  128'(resp_dz), 128'(dz));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge divider_clk);
        reset = 1'b0;
    endtask

    logic [31:0] t3_quo [5] = '{33, 28, 27, 30, 33};
    logic [31:0] t3_rem [5] = '{1, 4, 3, 10, 1};
    int          t3_gnt [5] = '{0, 1, 2, 3, 0};

    initial begin
        int gc, hc, c0;

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge divider_clk);
        #1 check("rst_outs",
                 {busy, resp_valid, div_i_call, div_reset_n, resp_dz, req_ready, resp_id, resp_quo, resp_rem},
                 128'd0);
        @(negedge divider_clk);
        reset = 1'b0;
        resp_ready = 1'b1;

        // 1: single request on req0
        set_req(0, 1'b1, 32'd100, 32'd7);
        serve("t1", 0, 32'd14, 32'd2, 1'b0, LAT, 1'b1, gc);
        @(negedge divider_clk);
        #1 check("t1_idle", {busy, resp_valid}, 128'd0);

        // 2: divide by zero answered locally
        c0 = call_cnt;
        set_req(1, 1'b1, 32'h1234, 32'd0);
        serve("t2", 1, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, 1'b1, gc);
        @(negedge divider_clk);
        check("t2_nocall", 128'(call_cnt - c0), 128'd0);

        // 3: everyone held valid, back-to-back round robin from a reset pointer
        do_reset();
        set_req(0, 1'b1, 32'd100, 32'd3);
        set_req(1, 1'b1, 32'd200, 32'd7);
        set_req(2, 1'b1, 32'd300, 32'd11);
        set_req(3, 1'b1, 32'd400, 32'd13);
        for (int n = 0; n < 5; n++)
            serve("t3", t3_gnt[n], t3_quo[n], t3_rem[n], 1'b0, LAT, 1'b0, gc);
        req_valid = '0;
        @(negedge divider_clk);

        // 4: backpressure in RESP; a pending request must wait for the handshake
        resp_ready = 1'b0;
        set_req(2, 1'b1, 32'd50, 32'd6);
        serve("t4", 2, 32'd8, 32'd2, 1'b0, LAT, 1'b1, gc);
        set_req(0, 1'b1, 32'd21, 32'd4);
        for (int n = 0; n < 10; n++) begin
            @(negedge divider_clk);
            #1 check("t4_hold", {resp_valid, busy, req_ready, resp_id, resp_quo, resp_rem},
                     {1'b1, 1'b1, 4'b0000, 2'd2, 32'd8, 32'd2});
        end
        resp_ready = 1'b1;
        hc = cyc;
        #1 check("t4_hs_nogrant", {resp_valid, req_ready}, {1'b1, 4'b0000});
        serve("t4b", 0, 32'd5, 32'd1, 1'b0, LAT, 1'b1, gc);
        check("t4b_next", 128'(gc - hc), 128'd1);

        // 5: reset in the 5th RUN cycle, then reissue
        set_req(1, 1'b1, 32'd9, 32'd3);
        wait_grant(c0, gc);
        check("t5_gnt", 128'(c0), 128'd1);
        @(negedge divider_clk);
        req_valid[1] = 1'b0;
        repeat (12) @(negedge divider_clk);
        #1 check("t5_run", {busy, div_i_call, div_reset_n, div_num, div_den},
                 {1'b1, 1'b1, 1'b1, 32'd9, 32'd3});
        reset = 1'b1;
        @(negedge divider_clk);
        #1 check("t5_abort", {busy, resp_valid, div_i_call, div_reset_n, req_ready}, 128'd0);
        reset = 1'b0;
        set_req(1, 1'b1, 32'd9, 32'd3);
        serve("t5r", 1, 32'd3, 32'd0, 1'b0, LAT, 1'b1, gc);

        // 6: req3 then req1/req2 -> pointer wraps, req1 before req2
        set_req(3, 1'b1, 32'd17, 32'd5);
        serve("t6a", 3, 32'd3, 32'd2, 1'b0, LAT, 1'b1, gc);
        set_req(1, 1'b1, 32'd1000, 32'd10);
        set_req(2, 1'b1, 32'd77, 32'd0);
        serve("t6b", 1, 32'd100, 32'd0, 1'b0, LAT, 1'b1, gc);
        serve("t6c", 2, 32'hFFFF_FFFF, 32'd77, 1'b1, 1, 1'b1, gc);
        @(negedge divider_clk);
        #1 check("t6_idle", {busy, resp_valid, req_ready}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
